// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle signed non-restoring divider; DIV_ZERO_TRAP_EN enables the divide-by-zero trap
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] a, a_sh, a_step, a_fix;
  logic [WIDTH-1:0] q, m, dvd, dsr;
  logic sq, sr, dz_hit;
`ifdef DIV_ZERO_TRAP_EN
  logic dz;
  assign dz_hit = (dsr == '0);
  assign div_by_zero = dz;
`else
  assign dz_hit = 1'b0;
  assign div_by_zero = 1'b0;
`endif
  assign busy   = (state == PREP) || (state == ITER) || (state == FIX);
  assign done   = (state == DONE);
  assign a_sh   = {a[WIDTH-1:0], q[WIDTH-1]};
  assign a_step = a[WIDTH] ? a_sh + {1'b0, m} : a_sh - {1'b0, m};
  assign a_fix  = a[WIDTH] ? a + {1'b0, m} : a;
  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  // next-state sequencing
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = start ? PREP : IDLE;
      PREP: state_n = dz_hit ? DONE : ITER;
      ITER: state_n = (cnt == CW'(WIDTH-1)) ? FIX : ITER;
      FIX:  state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // operand capture, one non-restoring step per ITER cycle, sign fix-up into the result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      a <= '0;
      q <= '0;
      m <= '0;
      cnt <= '0;
      dvd <= '0;
      dsr <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
      quotient <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_TRAP_EN
      dz <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (start) begin
          dvd <= dividend;
          dsr <= divisor;
`ifdef DIV_ZERO_TRAP_EN
          dz <= 1'b0;
`endif
        end
        PREP: begin
          m <= dsr[WIDTH-1] ? -dsr : dsr;
          q <= dvd[WIDTH-1] ? -dvd : dvd;
          a <= '0;
          cnt <= '0;
          sq <= dvd[WIDTH-1] ^ dsr[WIDTH-1];
          sr <= dvd[WIDTH-1];
`ifdef DIV_ZERO_TRAP_EN
          if (dz_hit) begin
            quotient <= '1;
            remainder <= dvd;
            dz <= 1'b1;
          end
`endif
        end
        ITER: begin
          a <= a_step;
          q <= {q[WIDTH-2:0], ~a_step[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          a <= a_fix;
          quotient <= sq ? -q : q;
          remainder <= sr ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule
